// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler for the SDRAM frame store.
// Rotates write/pending/read buffer roles between the frame writer and display.
module frame_buffer_scheduler #(
    parameter int unsigned ADDR_BITS    = 21,
    parameter int unsigned FRAME_STRIDE = 307200,
    parameter int unsigned CNT_BITS     = 16
) (
    input  logic                 mem_clk,
    input  logic                 rst,
    input  logic                 wr_frame_start,
    input  logic                 wr_frame_done,
    input  logic                 rd_frame_start,
    input  logic                 freeze,
    output logic [1:0]           write_addr_index,
    output logic [ADDR_BITS-1:0] write_base_addr,
    output logic [1:0]           read_addr_index,
    output logic [ADDR_BITS-1:0] read_base_addr,
    output logic                 pending_valid,
    output logic [CNT_BITS-1:0]  drop_cnt,
    output logic [CNT_BITS-1:0]  repeat_cnt,
    output logic                 proto_err
);

    typedef enum logic {
        W_IDLE,
        W_ACTIVE
    } wstate_t;

    localparam logic [ADDR_BITS-1:0] BASE1 = ADDR_BITS'(FRAME_STRIDE);
    localparam logic [ADDR_BITS-1:0] BASE2 = ADDR_BITS'(2 * FRAME_STRIDE);
    localparam logic [CNT_BITS-1:0]  CMAX  = '1;

    function automatic logic [ADDR_BITS-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd1:    base_of = BASE1;
            2'd2:    base_of = BASE2;
            default: base_of = '0;
        endcase
    endfunction

    wstate_t              wst_q;
    logic [1:0]           w_q, p_q, r_q;
    logic [1:0]           w_d, p_d, r_d;
    logic                 pv_q, pv_d;
    logic [CNT_BITS-1:0]  drop_q, drop_d;
    logic [CNT_BITS-1:0]  rep_q, rep_d;
    logic                 perr_q, perr_d;
    logic [ADDR_BITS-1:0] wb_q, rb_q;

    logic publish;
    logic rd_swap;
    logic seq_err;

    assign publish = (wst_q == W_ACTIVE) && wr_frame_done;
    assign rd_swap = rd_frame_start && !freeze;
    assign seq_err = ((wst_q == W_ACTIVE) && wr_frame_start && !wr_frame_done)
                  || ((wst_q == W_IDLE) && wr_frame_done);

    // Writer FSM; start+done together while active closes one frame and opens the next.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            wst_q <= W_IDLE;
        end else begin
            case (wst_q)
                W_IDLE:   if (wr_frame_start) wst_q <= W_ACTIVE;
                W_ACTIVE: if (wr_frame_done && !wr_frame_start) wst_q <= W_IDLE;
                default:  wst_q <= W_IDLE;
            endcase
        end
    end

    // Role rotation, pending flag and saturating event counters.
    always_comb begin
        w_d    = w_q;
        p_d    = p_q;
        r_d    = r_q;
        pv_d   = pv_q;
        drop_d = drop_q;
        rep_d  = rep_q;
        perr_d = perr_q | seq_err;
        if (publish && rd_swap) begin
            if (pv_q) begin
                r_d = p_q;
                p_d = w_q;
                w_d = r_q;
            end else begin
                r_d = w_q;
                w_d = r_q;
            end
        end else if (publish) begin
            w_d  = p_q;
            p_d  = w_q;
            pv_d = 1'b1;
            if (pv_q && drop_q != CMAX) drop_d = drop_q + CNT_BITS'(1);
        end else if (rd_swap) begin
            if (pv_q) begin
                r_d  = p_q;
                p_d  = r_q;
                pv_d = 1'b0;
            end else if (rep_q != CMAX) begin
                rep_d = rep_q + CNT_BITS'(1);
            end
        end
    end

    // State and registered outputs; bases follow the next-state indices.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            w_q    <= 2'd0;
            p_q    <= 2'd1;
            r_q    <= 2'd2;
            wb_q   <= '0;
            rb_q   <= BASE2;
            pv_q   <= 1'b0;
            drop_q <= '0;
            rep_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            w_q    <= w_d;
            p_q    <= p_d;
            r_q    <= r_d;
            wb_q   <= base_of(w_d);
            rb_q   <= base_of(r_d);
            pv_q   <= pv_d;
            drop_q <= drop_d;
            rep_q  <= rep_d;
            perr_q <= perr_d;
        end
    end

    assign write_addr_index = w_q;
    assign write_base_addr  = wb_q;
    assign read_addr_index  = r_q;
    assign read_base_addr   = rb_q;
    assign pending_valid    = pv_q;
    assign drop_cnt         = drop_q;
    assign repeat_cnt       = rep_q;
    assign proto_err        = perr_q;

endmodule
